// File: rtl/mfcc_pkg.sv
// Shared constants and types for the MFCC frame egress block.
package mfcc_pkg;

  localparam int NUM_CEPS_DEF   = 12;
  localparam int CEPS_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF  = 8;

  // Sync byte that opens each frame when frame headers are enabled.
  localparam logic [7:0] HDR_SYNC = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    STREAM = 2'd2
  } tx_state_t;

endpackage

// File: rtl/mfcc_frame_tx_if.sv
// Word stream carrying finished cepstral frames (valid/ready with end-of-frame marker).
interface mfcc_frame_tx_if #(
  parameter int W = 16
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/ceps_pingpong.sv
// Two-bank coefficient store: the DCT fills the write bank while the reader drains the other.
// Per-bank valid masks make unwritten coefficients read back as zero.
module ceps_pingpong #(
  parameter int NUM_CEPS   = 12,
  parameter int CEPS_WIDTH = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [PTR_WIDTH-1:0]  wr_ptr,
  input  logic [CEPS_WIDTH-1:0] wr_data,
  input  logic                  swap,
  input  logic                  discard,
  input  logic [PTR_WIDTH-1:0]  rd_idx,
  output logic [CEPS_WIDTH-1:0] rd_data,
  output logic [CEPS_WIDTH-1:0] head_data
);

  logic [CEPS_WIDTH-1:0] bank [2][NUM_CEPS];
  logic [NUM_CEPS-1:0]   mask [2];
  logic                  wr_bank;
  logic                  rd_bank;
  logic                  wr_ok;

  assign rd_bank = ~wr_bank;
  assign wr_ok   = wr_en && (int'(wr_ptr) < NUM_CEPS);

  // Coefficient storage; contents are qualified by the masks, so no reset needed.
  always_ff @(posedge clk) begin
    if (wr_ok) bank[wr_bank][wr_ptr] <= wr_data;
  end

  // Valid masks and bank select. A discarded frame only loses its mask bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask[0] <= '0;
      mask[1] <= '0;
      wr_bank <= 1'b0;
    end else if (discard) begin
      mask[wr_bank] <= '0;
    end else begin
      if (wr_ok) mask[wr_bank][wr_ptr] <= 1'b1;
      if (swap) begin
        mask[rd_bank] <= '0;
        wr_bank       <= rd_bank;
      end
    end
  end

  // Read mux from the read bank; out-of-range or unwritten indices give zero.
  always_comb begin
    rd_data = '0;
    if ((int'(rd_idx) < NUM_CEPS) && mask[rd_bank][rd_idx]) rd_data = bank[rd_bank][rd_idx];
  end

  // Coefficient 0 of the frame being committed, including a write landing on the commit edge.
  always_comb begin
    head_data = '0;
    if (wr_ok && (wr_ptr == '0))  head_data = wr_data;
    else if (mask[wr_bank][0])    head_data = bank[wr_bank][0];
  end

endmodule

// File: rtl/mfcc_frame_tx.sv
// Egress end of the DCT output: commits finished frames into a ping-pong store and streams them
// out word by word. Frames arriving while the reader is busy are dropped whole.
// Build option: MFCC_TX_HEADER_EN prepends {8'hA5, frame_count} to every frame.
module mfcc_frame_tx
  import mfcc_pkg::*;
#(
  parameter int NUM_CEPS   = NUM_CEPS_DEF,
  parameter int CEPS_WIDTH = CEPS_WIDTH_DEF,
  parameter int PTR_WIDTH  = $clog2(NUM_CEPS),
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dct_valid_i,
  input  logic [PTR_WIDTH-1:0]  ceps_ptr_i,
  input  logic [CEPS_WIDTH-1:0] ceps_i,
  input  logic                  dct_done_i,
  mfcc_frame_tx_if.master       m,
  output logic [CNT_WIDTH-1:0]  frame_count_o,
  output logic [CNT_WIDTH-1:0]  drop_count_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

`ifdef MFCC_TX_HEADER_EN
  localparam tx_state_t FIRST = HEADER;
`else
  localparam tx_state_t FIRST = STREAM;
`endif

  tx_state_t             state, state_nxt;
  logic [PTR_WIDTH-1:0]  idx, rd_idx;
  logic [CEPS_WIDTH-1:0] out_data, rd_data, head_data, first_word;
  logic [CNT_WIDTH-1:0]  frame_cnt, frame_cnt_nxt, drop_cnt;
  logic                  overrun;
  logic                  valid, is_last, hs, last_hs, rd_free, commit, drop;

  ceps_pingpong #(
    .NUM_CEPS   (NUM_CEPS),
    .CEPS_WIDTH (CEPS_WIDTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (dct_valid_i),
    .wr_ptr    (ceps_ptr_i),
    .wr_data   (ceps_i),
    .swap      (commit),
    .discard   (drop),
    .rd_idx    (rd_idx),
    .rd_data   (rd_data),
    .head_data (head_data)
  );

  // Reader state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: a commit coinciding with the final handshake restarts without an idle gap.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (commit) state_nxt = FIRST;
      HEADER:  if (hs) state_nxt = STREAM;
      STREAM:  if (last_hs) state_nxt = commit ? FIRST : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded handshake, commit/drop decisions and next-word selection.
  always_comb begin
    valid         = (state != IDLE);
    is_last       = (state == STREAM) && (idx == PTR_WIDTH'(NUM_CEPS - 1));
    hs            = valid && m.ready;
    last_hs       = hs && is_last;
    rd_free       = (state == IDLE) || last_hs;
    commit        = dct_done_i && rd_free;
    drop          = dct_done_i && !rd_free;
    rd_idx        = (state == HEADER) ? '0 : idx + 1'b1;
    frame_cnt_nxt = frame_cnt + CNT_WIDTH'(last_hs);
`ifdef MFCC_TX_HEADER_EN
    first_word    = CEPS_WIDTH'({HDR_SYNC, frame_cnt_nxt[7:0]});
`else
    first_word    = head_data;
`endif
  end

  // Output word register, word index and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      out_data  <= '0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun   <= drop;
      frame_cnt <= frame_cnt_nxt;
      if (drop) drop_cnt <= drop_cnt + 1'b1;
      if (commit) begin
        idx      <= '0;
        out_data <= first_word;
      end else if (hs && (state == HEADER)) begin
        idx      <= '0;
        out_data <= rd_data;
      end else if (hs && !is_last) begin
        idx      <= idx + 1'b1;
        out_data <= rd_data;
      end
    end
  end

  assign m.valid       = valid;
  assign m.data        = out_data;
  assign m.last        = is_last;
  assign frame_count_o = frame_cnt;
  assign drop_count_o  = drop_cnt;
  assign overrun_o     = overrun;
  assign busy_o        = valid;

endmodule

// File: tb/tb_mfcc_frame_tx.sv
// Directed bench for mfcc_frame_tx: frame tables plus hand-written corner sequences.
module tb_mfcc_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dct_valid;
  logic [3:0]  ceps_ptr;
  logic [15:0] ceps;
  logic        dct_done;
  logic [7:0]  frame_count, drop_count;
  logic        overrun, busy;

  int tests  = 0;
  int failed = 0;

  mfcc_frame_tx_if #(.W(16)) mif ();

  mfcc_frame_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dct_valid_i   (dct_valid),
    .ceps_ptr_i    (ceps_ptr),
    .ceps_i        (ceps),
    .dct_done_i    (dct_done),
    .m             (mif.master),
    .frame_count_o (frame_count),
    .drop_count_o  (drop_count),
    .overrun_o     (overrun),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          n;
    logic [3:0]  ptr [4];
    logic [15:0] dat [4];
    logic [15:0] exp [12];
  } fvec_t;

  fvec_t tbl [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] p, input logic [15:0] d, input logic done);
    dct_valid = 1'b1;
    ceps_ptr  = p;
    ceps      = d;
    dct_done  = done;
    tick();
    dct_valid = 1'b0;
    dct_done  = 1'b0;
  endtask

  // Drains one frame; fc is the frame count before this frame (used for the header word).
  task automatic recv_frame(input string name, input logic [15:0] e12 [12], input int fc, input bit rnd);
    logic [15:0] ew [13];
    logic [15:0] held;
    int          nw, got, guard;
    bit          stalled, rdy;
`ifdef MFCC_TX_HEADER_EN
    ew[0] = {8'hA5, 8'(fc)};
    for (int i = 0; i < 12; i++) ew[i+1] = e12[i];
    nw = 13;
`else
    for (int i = 0; i < 12; i++) ew[i] = e12[i];
    ew[12] = '0;
    nw = 12;
`endif
    got = 0; guard = 0; stalled = 0; held = '0;
    while (got < nw && guard < 2000) begin
      if (stalled) begin
        check({name, " stall valid"}, 32'(mif.valid), 32'd1);
        check({name, " stall data"}, 32'(mif.data), 32'(held));
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mif.ready = rdy;
      if (mif.valid && rdy) begin
        check($sformatf("%s w%0d data", name, got), 32'(mif.data), 32'(ew[got]));
        check($sformatf("%s w%0d last", name, got), 32'(mif.last), 32'(got == nw - 1));
        got++;
        stalled = 0;
      end else if (mif.valid) begin
        stalled = 1;
        held    = mif.data;
      end else begin
        stalled = 0;
      end
      tick();
      guard++;
    end
    mif.ready = 1'b0;
    if (guard >= 2000) check({name, " timeout words"}, 32'(got), 32'(nw));
    check({name, " frame_count"}, 32'(frame_count), 32'(fc + 1));
  endtask

  initial begin
    logic [15:0] e [12];
    logic [15:0] a_first;
    bit          seen;

    tbl[0].name = "sparse";    tbl[0].n = 2;
    tbl[0].ptr  = '{4'd12, 4'd3, 4'd0, 4'd0};
    tbl[0].dat  = '{16'h1234, 16'h7FFF, 16'h0, 16'h0};
    tbl[0].exp  = '{16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    tbl[1].name = "overwrite"; tbl[1].n = 4;
    tbl[1].ptr  = '{4'd5, 4'd0, 4'd5, 4'd11};
    tbl[1].dat  = '{16'h1111, 16'hABCD, 16'h2222, 16'hFFFF};
    tbl[1].exp  = '{16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF};
    tbl[2].name = "edges";     tbl[2].n = 3;
    tbl[2].ptr  = '{4'd15, 4'd1, 4'd10, 4'd0};
    tbl[2].dat  = '{16'h5555, 16'h8000, 16'h0001, 16'h0};
    tbl[2].exp  = '{16'h0, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0001, 16'h0};

    rst_n = 1'b0; dct_valid = 1'b0; ceps_ptr = '0; ceps = '0; dct_done = 1'b0; mif.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", 32'(mif.valid), 0);
    check("reset last", 32'(mif.last), 0);
    check("reset data", 32'(mif.data), 0);
    check("reset frame_count", 32'(frame_count), 0);
    check("reset drop_count", 32'(drop_count), 0);
    check("reset overrun", 32'(overrun), 0);
    check("reset busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Full frame, ready held high; valid must rise right after the commit edge.
    for (int i = 0; i < 12; i++) begin
      wr(4'(i), 16'h0100 + 16'(i), i == 11);
      e[i] = 16'h0100 + 16'(i);
    end
    check("t1 latency valid", 32'(mif.valid), 1);
    check("t1 busy", 32'(busy), 1);
    recv_frame("t1", e, 0, 0);
    check("t1 idle busy", 32'(busy), 0);

    // Random backpressure.
    for (int i = 0; i < 12; i++) begin
      wr(4'(i), 16'h0200 + 16'(i), i == 11);
      e[i] = 16'h0200 + 16'(i);
    end
    recv_frame("t2", e, 1, 1);

    // Sparse / illegal-pointer frames from the table; last write shares the done cycle.
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < tbl[t].n; k++) wr(tbl[t].ptr[k], tbl[t].dat[k], k == tbl[t].n - 1);
      recv_frame(tbl[t].name, tbl[t].exp, 2 + t, 0);
    end

    // Overrun: second frame committed while the first is stalled.
    wr(4'd0, 16'hAAAA, 1'b1);
    a_first = mif.data;
    wr(4'd0, 16'hBBBB, 1'b1);
    check("t3 overrun pulse", 32'(overrun), 1);
    check("t3 drop_count", 32'(drop_count), 1);
    check("t3 busy", 32'(busy), 1);
    tick();
    check("t3 overrun single", 32'(overrun), 0);
    check("t3 head undisturbed", 32'(mif.data), 32'(a_first));
    check("t3 valid held", 32'(mif.valid), 1);
    e = '{16'hAAAA, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    recv_frame("t3a", e, 5, 0);
    wr(4'd11, 16'hCCCC, 1'b1);
    e = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hCCCC};
    recv_frame("t3c", e, 6, 0);
    check("t3 drop_count final", 32'(drop_count), 1);

    // Back-to-back: commit on the final handshake, with coefficient 0 written that same cycle.
    wr(4'd0, 16'hD000, 1'b0);
    wr(4'd11, 16'hD00B, 1'b1);
    wr(4'd1, 16'hE001, 1'b0);
    mif.ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (mif.valid && mif.last) begin
        check("t5 last word", 32'(mif.data), 32'hD00B);
        dct_done = 1'b1; dct_valid = 1'b1; ceps_ptr = 4'd0; ceps = 16'hE000;
        seen = 1;
      end
      tick();
    end
    dct_done = 1'b0; dct_valid = 1'b0; mif.ready = 1'b0;
    check("t5 last seen", 32'(seen), 1);
    check("t5 valid next", 32'(mif.valid), 1);
    check("t5 no overrun", 32'(overrun), 0);
    check("t5 drop_count", 32'(drop_count), 1);
    check("t5 frame_count", 32'(frame_count), 8);
    e = '{16'hE000, 16'hE001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    recv_frame("t5e", e, 8, 0);

    // Reset in the middle of a frame.
    wr(4'd2, 16'hF002, 1'b1);
    mif.ready = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    #2;
    check("rst valid", 32'(mif.valid), 0);
    check("rst data", 32'(mif.data), 0);
    check("rst frame_count", 32'(frame_count), 0);
    check("rst drop_count", 32'(drop_count), 0);
    check("rst busy", 32'(busy), 0);
    mif.ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr(4'd5, 16'h0055, 1'b1);
    e = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0055, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    recv_frame("post_rst", e, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
